// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: funct3 encodings, FSM states
// and the alignment rule used to decide whether a bus request is issued.
package mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    RESP = 2'b10
  } mem_state_t;

  // funct3[1:0] gives the access size; 11 is treated as a word access.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    if (funct3[1:0] == 2'b00)
      return 1'b0;
    else if (funct3[1:0] == 2'b01)
      return addr_lo[0];
    else
      return addr_lo != 2'b00;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the data bus: store byte enables and data replication,
// plus load byte/halfword extraction with sign or zero extension.
module lsu_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] load_raw,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  load_byte;
  logic [15:0] load_half;

  always_comb begin
    be    = 4'b1111;
    wdata = store_data;
    case (funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{store_data[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = store_data;
      end
    endcase
  end

  // Unknown load encodings fall through to a full-word result.
  always_comb begin
    load_byte = load_raw[7:0];
    case (addr_lo)
      2'b00:   load_byte = load_raw[7:0];
      2'b01:   load_byte = load_raw[15:8];
      2'b10:   load_byte = load_raw[23:16];
      default: load_byte = load_raw[31:24];
    endcase
    load_half = addr_lo[1] ? load_raw[31:16] : load_raw[15:0];
    load_data = load_raw;
    case (funct3)
      F3_LB:   load_data = {{24{load_byte[7]}}, load_byte};
      F3_LH:   load_data = {{16{load_half[15]}}, load_half};
      F3_LBU:  load_data = {24'h000000, load_byte};
      F3_LHU:  load_data = {16'h0000, load_half};
      default: load_data = load_raw;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory-access stage: accepts from execute, runs the req/gnt/rvalid
// handshake with data memory and registers results into the MEM/WB boundary.
module mem_stage
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [31:0] alu_i,
  input  logic [31:0] rs2_i,
  input  logic        mem_rd_i,
  input  logic        mem_wr_i,
  input  logic [2:0]  funct3_i,
  input  logic [4:0]  rd_i,
  input  logic        reg_we_i,
  input  logic [1:0]  wb_sel1_i,
  input  logic [1:0]  wb_sel2_i,
  input  logic [1:0]  pc_sel_i,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        valid_o,
  output logic [31:0] alu_o,
  output logic [31:0] mem_o,
  output logic [4:0]  rd_o,
  output logic        reg_we_o,
  output logic [1:0]  wb_sel1_o,
  output logic [1:0]  wb_sel2_o,
  output logic [1:0]  pc_sel_o,
  output logic        misalign_o
);

  mem_state_t state, next_state;

  logic [31:0] lat_alu;
  logic [31:0] lat_rs2;
  logic [2:0]  lat_funct3;
  logic        lat_we;
  logic [4:0]  lat_rd;
  logic        lat_reg_we;
  logic [1:0]  lat_wb_sel1;
  logic [1:0]  lat_wb_sel2;
  logic [1:0]  lat_pc_sel;

  logic        accept;
  logic        is_mem;
  logic        misaligned;
  logic        start_bus;
  logic        quick_done;
  logic        store_done;
  logic        load_done;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] load_data;

  assign accept     = (state == IDLE) && valid_i;
  assign is_mem     = mem_rd_i | mem_wr_i;
  assign misaligned = is_mem & is_misaligned(funct3_i, alu_i[1:0]);
  assign start_bus  = accept & is_mem & ~misaligned;
  assign quick_done = accept & ~start_bus;
  assign store_done = (state == REQ) && dmem_gnt_i && lat_we;
  assign load_done  = (state == RESP) && dmem_rvalid_i;

  lsu_align u_align (
    .funct3     (lat_funct3),
    .addr_lo    (lat_alu[1:0]),
    .store_data (lat_rs2),
    .load_raw   (dmem_rdata_i),
    .be         (be),
    .wdata      (wdata),
    .load_data  (load_data)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= next_state;
  end

  // Bus outputs are forced to zero outside REQ so idle cycles show a quiet bus.
  always_comb begin
    next_state   = state;
    stall_o      = (state != IDLE);
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    dmem_addr_o  = 32'h0;
    dmem_be_o    = 4'h0;
    dmem_wdata_o = 32'h0;
    case (state)
      IDLE: begin
        if (start_bus)
          next_state = REQ;
      end
      REQ: begin
        dmem_req_o   = 1'b1;
        dmem_we_o    = lat_we;
        dmem_addr_o  = {lat_alu[31:2], 2'b00};
        dmem_be_o    = be;
        dmem_wdata_o = wdata;
        if (dmem_gnt_i)
          next_state = lat_we ? IDLE : RESP;
      end
      RESP: begin
        if (dmem_rvalid_i)
          next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_alu     <= 32'h0;
      lat_rs2     <= 32'h0;
      lat_funct3  <= 3'b000;
      lat_we      <= 1'b0;
      lat_rd      <= 5'd0;
      lat_reg_we  <= 1'b0;
      lat_wb_sel1 <= 2'b00;
      lat_wb_sel2 <= 2'b00;
      lat_pc_sel  <= 2'b00;
    end else if (accept) begin
      lat_alu     <= alu_i;
      lat_rs2     <= rs2_i;
      lat_funct3  <= funct3_i;
      lat_we      <= mem_wr_i;
      lat_rd      <= rd_i;
      lat_reg_we  <= reg_we_i;
      lat_wb_sel1 <= wb_sel1_i;
      lat_wb_sel2 <= wb_sel2_i;
      lat_pc_sel  <= pc_sel_i;
    end
  end

  // Single-cycle ops complete straight from the inputs; bus ops from the latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o    <= 1'b0;
      alu_o      <= 32'h0;
      mem_o      <= 32'h0;
      rd_o       <= 5'd0;
      reg_we_o   <= 1'b0;
      wb_sel1_o  <= 2'b00;
      wb_sel2_o  <= 2'b00;
      pc_sel_o   <= 2'b00;
      misalign_o <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (quick_done) begin
        valid_o    <= 1'b1;
        alu_o      <= alu_i;
        mem_o      <= 32'h0;
        rd_o       <= rd_i;
        reg_we_o   <= reg_we_i & ~misaligned;
        wb_sel1_o  <= wb_sel1_i;
        wb_sel2_o  <= wb_sel2_i;
        pc_sel_o   <= pc_sel_i;
        misalign_o <= misaligned;
      end else if (store_done || load_done) begin
        valid_o    <= 1'b1;
        alu_o      <= lat_alu;
        mem_o      <= load_done ? load_data : 32'h0;
        rd_o       <= lat_rd;
        reg_we_o   <= lat_reg_we;
        wb_sel1_o  <= lat_wb_sel1;
        wb_sel2_o  <= lat_wb_sel2;
        pc_sel_o   <= lat_pc_sel;
        misalign_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed table-driven bench for mem_stage with hand-computed expectations,
// plus sequences for reset during a load and back-to-back issue under stall.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [31:0] alu_i;
  logic [31:0] rs2_i;
  logic        mem_rd_i;
  logic        mem_wr_i;
  logic [2:0]  funct3_i;
  logic [4:0]  rd_i;
  logic        reg_we_i;
  logic [1:0]  wb_sel1_i;
  logic [1:0]  wb_sel2_i;
  logic [1:0]  pc_sel_i;
  logic        stall_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        valid_o;
  logic [31:0] alu_o;
  logic [31:0] mem_o;
  logic [4:0]  rd_o;
  logic        reg_we_o;
  logic [1:0]  wb_sel1_o;
  logic [1:0]  wb_sel2_o;
  logic [1:0]  pc_sel_o;
  logic        misalign_o;

  int    pass_cnt = 0;
  int    total_cnt = 0;
  string cur_test = "init";

  typedef struct {
    logic        mem_rd;
    logic        mem_wr;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] rs2;
    logic [31:0] rdata;
    int          gd;
    int          rvd;
    logic [4:0]  rd;
    logic        reg_we;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_mem;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[15];

  mem_stage dut (
    .clk           (clk),
    .rst           (rst),
    .valid_i       (valid_i),
    .alu_i         (alu_i),
    .rs2_i         (rs2_i),
    .mem_rd_i      (mem_rd_i),
    .mem_wr_i      (mem_wr_i),
    .funct3_i      (funct3_i),
    .rd_i          (rd_i),
    .reg_we_i      (reg_we_i),
    .wb_sel1_i     (wb_sel1_i),
    .wb_sel2_i     (wb_sel2_i),
    .pc_sel_i      (pc_sel_i),
    .stall_o       (stall_o),
    .dmem_req_o    (dmem_req_o),
    .dmem_we_o     (dmem_we_o),
    .dmem_addr_o   (dmem_addr_o),
    .dmem_be_o     (dmem_be_o),
    .dmem_wdata_o  (dmem_wdata_o),
    .dmem_gnt_i    (dmem_gnt_i),
    .dmem_rvalid_i (dmem_rvalid_i),
    .dmem_rdata_i  (dmem_rdata_i),
    .valid_o       (valid_o),
    .alu_o         (alu_o),
    .mem_o         (mem_o),
    .rd_o          (rd_o),
    .reg_we_o      (reg_we_o),
    .wb_sel1_o     (wb_sel1_o),
    .wb_sel2_o     (wb_sel2_o),
    .pc_sel_o      (pc_sel_o),
    .misalign_o    (misalign_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp)
      pass_cnt++;
    else
      $display("[TB] FAIL %s/%s: got 0x%08h expected 0x%08h", cur_test, name, act, exp);
  endtask

  // Drives one instruction, plays the memory side with the vector's delays,
  // and checks the bus cycles and the completion cycle.
  task automatic applyStimulus(input vec_t v, input int idx);
    logic [1:0] s1, s2, ps;
    logic       bus_op;
    s1 = 2'(idx);
    s2 = ~2'(idx);
    ps = 2'(idx >> 1);
    bus_op = (v.mem_rd | v.mem_wr) & ~v.exp_mis;
    cur_test = $sformatf("vec%0d", idx);
    valid_i   = 1'b1;
    alu_i     = v.alu;
    rs2_i     = v.rs2;
    mem_rd_i  = v.mem_rd;
    mem_wr_i  = v.mem_wr;
    funct3_i  = v.f3;
    rd_i      = v.rd;
    reg_we_i  = v.reg_we;
    wb_sel1_i = s1;
    wb_sel2_i = s2;
    pc_sel_i  = ps;
    checkOutput("stall_at_accept", 32'(stall_o), 32'd0);
    tick();
    valid_i  = 1'b0;
    mem_rd_i = 1'b0;
    mem_wr_i = 1'b0;
    if (bus_op) begin
      for (int i = 0; i <= v.gd; i++) begin
        checkOutput("req", 32'(dmem_req_o), 32'd1);
        checkOutput("we", 32'(dmem_we_o), 32'(v.mem_wr));
        checkOutput("addr", dmem_addr_o, v.exp_addr);
        checkOutput("be", 32'(dmem_be_o), 32'(v.exp_be));
        checkOutput("wdata", dmem_wdata_o, v.exp_wdata);
        checkOutput("stall_req", 32'(stall_o), 32'd1);
        checkOutput("bubble_req", 32'(valid_o), 32'd0);
        dmem_gnt_i    = (i == v.gd);
        dmem_rvalid_i = (i != v.gd);
        dmem_rdata_i  = 32'hDEADBEEF;
        tick();
      end
      dmem_gnt_i    = 1'b0;
      dmem_rvalid_i = 1'b0;
      if (v.mem_rd) begin
        for (int j = 0; j <= v.rvd; j++) begin
          checkOutput("req_low_resp", 32'(dmem_req_o), 32'd0);
          checkOutput("stall_resp", 32'(stall_o), 32'd1);
          checkOutput("bubble_resp", 32'(valid_o), 32'd0);
          dmem_gnt_i    = (j != v.rvd);
          dmem_rvalid_i = (j == v.rvd);
          dmem_rdata_i  = (j == v.rvd) ? v.rdata : 32'hBAADF00D;
          tick();
        end
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = 32'h0;
      end
    end
    checkOutput("valid", 32'(valid_o), 32'd1);
    checkOutput("alu", alu_o, v.alu);
    checkOutput("mem", mem_o, v.exp_mem);
    checkOutput("rd", 32'(rd_o), 32'(v.rd));
    checkOutput("reg_we", 32'(reg_we_o), 32'(v.reg_we & ~v.exp_mis));
    checkOutput("misalign", 32'(misalign_o), 32'(v.exp_mis));
    checkOutput("wb_sel1", 32'(wb_sel1_o), 32'(s1));
    checkOutput("wb_sel2", 32'(wb_sel2_o), 32'(s2));
    checkOutput("pc_sel", 32'(pc_sel_o), 32'(ps));
    checkOutput("req_done", 32'(dmem_req_o), 32'd0);
    checkOutput("stall_done", 32'(stall_o), 32'd0);
    tick();
    checkOutput("valid_one_cycle", 32'(valid_o), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    valid_i = 1'b0; alu_i = 32'h0; rs2_i = 32'h0; mem_rd_i = 1'b0; mem_wr_i = 1'b0;
    funct3_i = 3'b000; rd_i = 5'd0; reg_we_i = 1'b0;
    wb_sel1_i = 2'b00; wb_sel2_i = 2'b00; pc_sel_i = 2'b00;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;

    //            rd wr f3      alu           rs2           rdata         gd rvd rd    we  addr          be       wdata         mem           mis
    vecs[0]  = '{1'b0, 1'b0, 3'b000, 32'h00001234, 32'h0,        32'h0,        0, 0, 5'd5,  1'b1, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b0};
    vecs[1]  = '{1'b0, 1'b1, 3'b000, 32'h00000103, 32'hAABBCCDD, 32'h0,        2, 0, 5'd0,  1'b0, 32'h00000100, 4'b1000, 32'hDDDDDDDD, 32'h0,        1'b0};
    vecs[2]  = '{1'b1, 1'b0, 3'b000, 32'h00000102, 32'h0,        32'h0080FF00, 0, 0, 5'd1,  1'b1, 32'h00000100, 4'b0100, 32'h0,        32'hFFFFFF80, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 3'b100, 32'h00000102, 32'h0,        32'h0080FF00, 0, 0, 5'd2,  1'b1, 32'h00000100, 4'b0100, 32'h0,        32'h00000080, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 3'b001, 32'h00000102, 32'h0,        32'h0080FF00, 0, 0, 5'd3,  1'b1, 32'h00000100, 4'b1100, 32'h0,        32'h00000080, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 3'b010, 32'h00000106, 32'h0,        32'h0,        0, 0, 5'd4,  1'b1, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1};
    vecs[6]  = '{1'b0, 1'b1, 3'b001, 32'h00000102, 32'h12345678, 32'h0,        1, 0, 5'd0,  1'b0, 32'h00000100, 4'b1100, 32'h56785678, 32'h0,        1'b0};
    vecs[7]  = '{1'b0, 1'b1, 3'b010, 32'h00000200, 32'hCAFEBABE, 32'h0,        0, 0, 5'd0,  1'b0, 32'h00000200, 4'b1111, 32'hCAFEBABE, 32'h0,        1'b0};
    vecs[8]  = '{1'b1, 1'b0, 3'b101, 32'h00000200, 32'h0,        32'h1234F00D, 1, 2, 5'd6,  1'b1, 32'h00000200, 4'b0011, 32'h0,        32'h0000F00D, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 3'b001, 32'h00000202, 32'h0,        32'h80010000, 0, 1, 5'd7,  1'b1, 32'h00000200, 4'b1100, 32'h0,        32'hFFFF8001, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 3'b010, 32'h00000204, 32'h0,        32'h89ABCDEF, 2, 0, 5'd8,  1'b1, 32'h00000204, 4'b1111, 32'h0,        32'h89ABCDEF, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 3'b001, 32'h00000101, 32'h0000BEEF, 32'h0,        0, 0, 5'd0,  1'b0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1};
    vecs[12] = '{1'b1, 1'b0, 3'b000, 32'h00000101, 32'h0,        32'h00007F00, 0, 0, 5'd9,  1'b1, 32'h00000100, 4'b0010, 32'h0,        32'h0000007F, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 3'b111, 32'h00000300, 32'h0,        32'h11223344, 0, 0, 5'd10, 1'b1, 32'h00000300, 4'b1111, 32'h0,        32'h11223344, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 3'b101, 32'h00000103, 32'h0,        32'h0,        0, 0, 5'd12, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1};

    tick();
    tick();
    rst = 1'b0;
    cur_test = "reset";
    checkOutput("valid", 32'(valid_o), 32'd0);
    checkOutput("req", 32'(dmem_req_o), 32'd0);
    checkOutput("we", 32'(dmem_we_o), 32'd0);
    checkOutput("stall", 32'(stall_o), 32'd0);
    checkOutput("reg_we", 32'(reg_we_o), 32'd0);
    checkOutput("misalign", 32'(misalign_o), 32'd0);
    checkOutput("alu", alu_o, 32'd0);
    checkOutput("mem", mem_o, 32'd0);

    foreach (vecs[k]) applyStimulus(vecs[k], k);

    // Reset while waiting for read data; the late rvalid must be ignored.
    cur_test = "rst_mid";
    valid_i = 1'b1; alu_i = 32'h00000400; mem_rd_i = 1'b1; funct3_i = 3'b010;
    rd_i = 5'd11; reg_we_i = 1'b1;
    tick();
    valid_i = 1'b0; mem_rd_i = 1'b0;
    dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i = 1'b0;
    checkOutput("stall_resp", 32'(stall_o), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("stall_after_rst", 32'(stall_o), 32'd0);
    checkOutput("req_after_rst", 32'(dmem_req_o), 32'd0);
    checkOutput("valid_after_rst", 32'(valid_o), 32'd0);
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h00000055;
    tick();
    dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
    checkOutput("valid_late_rvalid", 32'(valid_o), 32'd0);
    checkOutput("alu_reset", alu_o, 32'd0);
    checkOutput("mem_reset", mem_o, 32'd0);
    checkOutput("reg_we_reset", 32'(reg_we_o), 32'd0);
    checkOutput("stall_idle", 32'(stall_o), 32'd0);
    tick();
    checkOutput("valid_still_low", 32'(valid_o), 32'd0);

    // Load followed by an ALU op that upstream holds while stalled.
    cur_test = "back2back";
    valid_i = 1'b1; alu_i = 32'h00000500; mem_rd_i = 1'b1; funct3_i = 3'b010;
    rd_i = 5'd13; reg_we_i = 1'b1;
    tick();
    mem_rd_i = 1'b0; alu_i = 32'h00ABCDEF; rd_i = 5'd14; funct3_i = 3'b000;
    checkOutput("stall_req", 32'(stall_o), 32'd1);
    dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i = 1'b0;
    checkOutput("stall_resp", 32'(stall_o), 32'd1);
    checkOutput("no_early_valid", 32'(valid_o), 32'd0);
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h13572468;
    tick();
    dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
    checkOutput("load_valid", 32'(valid_o), 32'd1);
    checkOutput("load_alu", alu_o, 32'h00000500);
    checkOutput("load_mem", mem_o, 32'h13572468);
    checkOutput("load_rd", 32'(rd_o), 32'd13);
    checkOutput("stall_free", 32'(stall_o), 32'd0);
    tick();
    valid_i = 1'b0;
    checkOutput("alu_valid", 32'(valid_o), 32'd1);
    checkOutput("alu_result", alu_o, 32'h00ABCDEF);
    checkOutput("alu_mem", mem_o, 32'd0);
    checkOutput("alu_rd", 32'(rd_o), 32'd14);
    tick();
    checkOutput("valid_drop", 32'(valid_o), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage of the RV32I core, between execute and write-back. Issues load/store transactions to data memory over a req/gnt/rvalid bus, with byte-lane alignment, store-data replication and load sign/zero extension. Stalls upstream while a transaction is outstanding. Registers ALU result, extended load data and write-back controls into the MEM/WB boundary consumed by the write-back stage.

## Interface
- No parameters; data and address width fixed at 32.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- valid_i  in  1  execute presents an instruction
- alu_i  in  32  ALU result / effective address
- rs2_i  in  32  store data
- mem_rd_i, mem_wr_i  in  1 each  load / store (never both)
- funct3_i  in  3  access size/sign
- rd_i  in  5; reg_we_i  in  1; wb_sel1_i, wb_sel2_i, pc_sel_i  in  2 each  — passthrough controls
- stall_o  out  1  upstream must hold its inputs
- dmem_req_o  out  1; dmem_we_o  out  1; dmem_addr_o  out  32 (bits[1:0]=0); dmem_be_o  out  4; dmem_wdata_o  out  32
- dmem_gnt_i  in  1; dmem_rvalid_i  in  1; dmem_rdata_i  in  32
- valid_o  out  1; alu_o  out  32; mem_o  out  32; rd_o  out  5; reg_we_o  out  1; wb_sel1_o, wb_sel2_o, pc_sel_o  out  2 each; misalign_o  out  1

## Operation
- FSM states IDLE, REQ, RESP. Accept only in IDLE when valid_i=1; accepted fields latched internally.
- Non-memory instruction: no bus activity, stays IDLE.
- Aligned memory op: IDLE→REQ. In REQ, dmem_req_o=1 with latched addr/we/be/wdata held stable until dmem_gnt_i. Store: REQ→IDLE on gnt. Load: REQ→RESP on gnt; RESP→IDLE on dmem_rvalid_i.
- dmem_rvalid_i ignored outside RESP; dmem_gnt_i ignored outside REQ.
- Misaligned (halfword with addr[0]=1, word with addr[1:0]≠0): no request, stays IDLE, completes as a 1-cycle op with misalign_o=1 and reg_we_o forced 0.
- Byte enables: byte → 4'b0001<<addr[1:0]; half → 0011 or 1100 by addr[1]; word → 1111. wdata: byte replicated ×4, half replicated ×2, word as-is.
- Load extraction by funct3: 000 LB sign-ext, 001 LH sign-ext, 010 LW, 100 LBU zero-ext, 101 LHU zero-ext; 011/110/111 treated as word.
- stall_o = (state ≠ IDLE), combinational.

## Timing
- Reset: state IDLE; dmem_req_o, dmem_we_o, valid_o, reg_we_o, misalign_o = 0; all data/control outputs 0.
- Output register updates on completion only; valid_o high exactly one cycle per instruction, 0 otherwise (bubbles during busy).
- Latency accept→valid_o: non-mem/misaligned 1 cycle; store 1 + cycles to gnt; load 1 + cycles to gnt + cycles to rvalid (minimum 3 if gnt in first REQ cycle and rvalid next).
- Store completion: valid_o in cycle after gnt; mem_o=0. Load: mem_o = extended rdata in cycle after rvalid.
- rst mid-transaction: returns to IDLE next edge, drops request, discards pending rvalid, no valid_o for the aborted instruction.
- Back-to-back: instruction held by upstream under stall_o is accepted in the first IDLE cycle.

## Structure
- Package mem_pkg: funct3 constants (F3_LB…F3_LHU), state enum mem_state_t.
- Sub-module lsu_align: combinational be/wdata generation and load extraction/extension; mem_stage holds FSM, latches and output register.

## Test plan
- ALU op alu_i=0x1234, reg_we_i=1 → next cycle valid_o=1, alu_o=0x1234, no dmem_req_o, stall_o never 1.
- SB rs2=0xAABBCCDD, addr=0x103, gnt after 2 cycles → dmem_addr_o=0x100, be=1000, wdata=0xDDDDDDDD held until gnt; valid_o cycle after gnt.
- LB addr=0x102, rdata=0x0080FF00, immediate gnt, rvalid next → mem_o=0xFFFFFF80; LBU same → 0x00000080; LH addr=0x102 → 0x00000080.
- LW addr=0x106 → no request, misalign_o=1, reg_we_o=0, valid_o after 1 cycle.
- Load, rst asserted in RESP, rvalid arrives after → FSM IDLE, valid_o stays 0, outputs reset values.
- Load followed by ALU op held under stall_o → ALU result valid_o exactly one cycle after load's valid_o.
